// File: rtl/uart_cmd_rx.sv
// UART command receiver: 8E1 frames (start, D0..D7, even parity, stop) assembled into
// {operand A, operand B, opcode}. Optional inter-byte timeout enabled by `define CMD_TIMEOUT_EN.
module uart_cmd_rx #(
    parameter int C_BPS        = 868,
    parameter int CNT_W        = 11,
    parameter int TIMEOUT_BITS = 32
) (
    input  logic       clk,
    input  logic       res,
    input  logic       RX,
    input  logic       en_RX_in,
    output logic       cmd_valid,
    output logic [7:0] cmd_a,
    output logic [7:0] cmd_b,
    output logic [1:0] cmd_op,
    output logic       cmd_err,
    output logic [1:0] cmd_err_code
);

    localparam logic [CNT_W-1:0] C_HALF = CNT_W'(C_BPS / 2 - 1);
    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(C_BPS - 1);

    localparam logic [1:0] E_TIMEOUT = 2'd0;
    localparam logic [1:0] E_PARITY  = 2'd1;
    localparam logic [1:0] E_FRAME   = 2'd2;
    localparam logic [1:0] E_OPCODE  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t           r_state;
    logic             r_rx_meta;
    logic             r_rxs;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit;
    logic [7:0]       r_data;
    logic             r_par;
    logic [1:0]       r_idx;
    logic [7:0]       r_a;
    logic [7:0]       r_b;
    logic             r_cmd_valid;
    logic [7:0]       r_cmd_a;
    logic [7:0]       r_cmd_b;
    logic [1:0]       r_cmd_op;
    logic             r_cmd_err;
    logic [1:0]       r_cmd_err_code;
    logic [2:0]       w_dec;

    // Even parity: the parity bit equals the XOR of the data bits.
    function automatic logic f_even_par(input logic [7:0] d);
        return ^d;
    endfunction

    // Opcode decode: {legal, op[1:0]}.
    function automatic logic [2:0] f_decode(input logic [7:0] b);
        case (b)
            8'h0a:   return 3'b100;
            8'h0b:   return 3'b101;
            8'h0c:   return 3'b110;
            8'h0d:   return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    assign w_dec = f_decode(r_data);

`ifdef CMD_TIMEOUT_EN
    localparam int GAP_LIM = TIMEOUT_BITS * C_BPS;
    localparam int GAP_W   = $clog2(GAP_LIM);
    logic [GAP_W-1:0] r_gap;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = (TIMEOUT_BITS > 0);
`endif

    // Two-flop synchroniser for the asynchronous serial line; idles high.
    always_ff @(posedge clk) begin
        if (res) begin
            r_rx_meta <= 1'b1;
            r_rxs     <= 1'b1;
        end else begin
            r_rx_meta <= RX;
            r_rxs     <= r_rx_meta;
        end
    end

    // Bit-level FSM, byte checks, command assembly and registered result pulses.
    always_ff @(posedge clk) begin
        if (res) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_bit          <= 3'd0;
            r_data         <= 8'h00;
            r_par          <= 1'b0;
            r_idx          <= 2'd0;
            r_a            <= 8'h00;
            r_b            <= 8'h00;
            r_cmd_valid    <= 1'b0;
            r_cmd_a        <= 8'h00;
            r_cmd_b        <= 8'h00;
            r_cmd_op       <= 2'd0;
            r_cmd_err      <= 1'b0;
            r_cmd_err_code <= 2'd0;
`ifdef CMD_TIMEOUT_EN
            r_gap          <= '0;
`endif
        end else begin
            r_cmd_valid <= 1'b0;
            r_cmd_err   <= 1'b0;
            if (!en_RX_in) begin
                r_state <= S_IDLE;
                r_idx   <= 2'd0;
                r_cnt   <= '0;
                r_bit   <= 3'd0;
`ifdef CMD_TIMEOUT_EN
                r_gap   <= '0;
`endif
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (!r_rxs) begin
                            r_cnt   <= '0;
                            r_state <= S_START;
                        end
                    end
                    S_START: begin
                        // Mid start bit: a high line here means the falling edge was a glitch.
                        if (r_cnt == C_HALF) begin
                            r_cnt <= '0;
                            r_bit <= 3'd0;
                            if (r_rxs) begin
                                r_state <= S_IDLE;
                            end else begin
                                r_state <= S_DATA;
                            end
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    S_DATA: begin
                        if (r_cnt == C_FULL) begin
                            r_cnt  <= '0;
                            r_data <= {r_rxs, r_data[7:1]};
                            r_bit  <= r_bit + 3'd1;
                            if (r_bit == 3'd7) begin
                                r_state <= S_PARITY;
                            end
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    S_PARITY: begin
                        if (r_cnt == C_FULL) begin
                            r_cnt   <= '0;
                            r_par   <= r_rxs;
                            r_state <= S_STOP;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    S_STOP: begin
                        if (r_cnt == C_FULL) begin
                            r_cnt   <= '0;
                            r_state <= S_IDLE;
                            if (!r_rxs) begin
                                r_cmd_err      <= 1'b1;
                                r_cmd_err_code <= E_FRAME;
                                r_idx          <= 2'd0;
                            end else if (r_par != f_even_par(r_data)) begin
                                r_cmd_err      <= 1'b1;
                                r_cmd_err_code <= E_PARITY;
                                r_idx          <= 2'd0;
                            end else begin
                                case (r_idx)
                                    2'd0: begin
                                        r_a   <= r_data;
                                        r_idx <= 2'd1;
                                    end
                                    2'd1: begin
                                        r_b   <= r_data;
                                        r_idx <= 2'd2;
                                    end
                                    default: begin
                                        // Operands reach the outputs only with a complete, legal command.
                                        r_idx <= 2'd0;
                                        if (w_dec[2]) begin
                                            r_cmd_valid <= 1'b1;
                                            r_cmd_a     <= r_a;
                                            r_cmd_b     <= r_b;
                                            r_cmd_op    <= w_dec[1:0];
                                        end else begin
                                            r_cmd_err      <= 1'b1;
                                            r_cmd_err_code <= E_OPCODE;
                                        end
                                    end
                                endcase
                            end
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end
                endcase
`ifdef CMD_TIMEOUT_EN
                // Gap timer only runs between bytes of a partially received command.
                if ((r_state == S_IDLE) && (r_idx != 2'd0)) begin
                    if (!r_rxs) begin
                        r_gap <= '0;
                    end else if (r_gap == GAP_W'(GAP_LIM - 1)) begin
                        r_gap          <= '0;
                        r_idx          <= 2'd0;
                        r_cmd_err      <= 1'b1;
                        r_cmd_err_code <= E_TIMEOUT;
                    end else begin
                        r_gap <= r_gap + GAP_W'(1);
                    end
                end else begin
                    r_gap <= '0;
                end
`endif
            end
        end
    end

    assign cmd_valid    = r_cmd_valid;
    assign cmd_a        = r_cmd_a;
    assign cmd_b        = r_cmd_b;
    assign cmd_op       = r_cmd_op;
    assign cmd_err      = r_cmd_err;
    assign cmd_err_code = r_cmd_err_code;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed self-checking bench for uart_cmd_rx; runs with a short bit period to keep the run brief.
module tb_uart_cmd_rx;

    localparam int C   = 32;
    localparam int TOB = 4;
    localparam int LAT = 3 + C / 2 + 10 * C;

    logic       clk = 1'b0;
    logic       res;
    logic       RX;
    logic       en_RX_in;
    logic       cmd_valid;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic [1:0] cmd_op;
    logic       cmd_err;
    logic [1:0] cmd_err_code;

    int n_err = 0;
    int n_chk = 0;
    int cyc   = 0;
    int t_start;
    bit saw_both = 1'b0;

    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic [1:0] qop[$];
    int         qvcyc[$];
    logic [1:0] qcode[$];
    int         qecyc[$];

    uart_cmd_rx #(.C_BPS(C), .CNT_W(11), .TIMEOUT_BITS(TOB)) dut (
        .clk(clk), .res(res), .RX(RX), .en_RX_in(en_RX_in),
        .cmd_valid(cmd_valid), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
        .cmd_err(cmd_err), .cmd_err_code(cmd_err_code)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every result pulse, sampled away from the active edge.
    always @(negedge clk) begin
        if (cmd_valid === 1'b1) begin
            qa.push_back(cmd_a);
            qb.push_back(cmd_b);
            qop.push_back(cmd_op);
            qvcyc.push_back(cyc);
        end
        if (cmd_err === 1'b1) begin
            qcode.push_back(cmd_err_code);
            qecyc.push_back(cyc);
        end
        if (cmd_valid === 1'b1 && cmd_err === 1'b1) saw_both = 1'b1;
    end

    task automatic clear_q();
        qa.delete(); qb.delete(); qop.delete(); qvcyc.delete();
        qcode.delete(); qecyc.delete();
    endtask

    task automatic bit_hold(input logic v);
        RX = v;
        repeat (C) @(negedge clk);
    endtask

    task automatic idle_bits(input int n);
        for (int i = 0; i < n; i++) bit_hold(1'b1);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic pflip, input logic stopb);
        t_start = cyc;
        bit_hold(1'b0);
        for (int i = 0; i < 8; i++) bit_hold(d[i]);
        bit_hold((^d) ^ pflip);
        bit_hold(stopb);
    endtask

    task automatic send_cmd(input logic [7:0] a, input logic [7:0] b, input logic [7:0] o);
        send_byte(a, 1'b0, 1'b1);
        send_byte(b, 1'b0, 1'b1);
        send_byte(o, 1'b0, 1'b1);
        bit_hold(1'b1);
    endtask

    // Start bit plus n data bits, then the line returns high (frame left unfinished).
    task automatic send_partial(input logic [7:0] d, input int n);
        bit_hold(1'b0);
        for (int i = 0; i < n; i++) bit_hold(d[i]);
    endtask

    task automatic test_reset();
        RX = 1'b1; en_RX_in = 1'b1; res = 1'b1;
        repeat (3) @(negedge clk);
        res = 1'b0;
        repeat (2) @(negedge clk);
        n_chk++; if (cmd_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", cmd_valid); end
        n_chk++; if (cmd_err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", cmd_err); end
        n_chk++; if (cmd_a !== 8'h00) begin n_err++; $display("FAIL reset_a: got %h want 00", cmd_a); end
        n_chk++; if (cmd_b !== 8'h00) begin n_err++; $display("FAIL reset_b: got %h want 00", cmd_b); end
        n_chk++; if (cmd_op !== 2'd0) begin n_err++; $display("FAIL reset_op: got %0d want 0", cmd_op); end
        n_chk++; if (cmd_err_code !== 2'd0) begin n_err++; $display("FAIL reset_code: got %0d want 0", cmd_err_code); end
    endtask

    task automatic test_basic();
        int t3;
        clear_q();
        send_byte(8'h0f, 1'b0, 1'b1);
        send_byte(8'h0e, 1'b0, 1'b1);
        send_byte(8'h0a, 1'b0, 1'b1);
        t3 = t_start;
        bit_hold(1'b1);
        n_chk++; if (qa.size() != 1) begin n_err++; $display("FAIL basic_nvalid: got %0d want 1", qa.size()); end
        n_chk++; if (qcode.size() != 0) begin n_err++; $display("FAIL basic_nerr: got %0d want 0", qcode.size()); end
        if (qa.size() == 1) begin
            n_chk++; if (qa[0] !== 8'h0f) begin n_err++; $display("FAIL basic_a: got %h want 0f", qa[0]); end
            n_chk++; if (qb[0] !== 8'h0e) begin n_err++; $display("FAIL basic_b: got %h want 0e", qb[0]); end
            n_chk++; if (qop[0] !== 2'd0) begin n_err++; $display("FAIL basic_op: got %0d want 0", qop[0]); end
            n_chk++; if (qvcyc[0] != t3 + LAT) begin n_err++; $display("FAIL basic_latency: got %0d want %0d", qvcyc[0], t3 + LAT); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] ops [4];
        ops[0] = 8'h0a; ops[1] = 8'h0b; ops[2] = 8'h0c; ops[3] = 8'h0d;
        clear_q();
        for (int k = 0; k < 4; k++) send_cmd(8'h0f, 8'h0e, ops[k]);
        n_chk++; if (qop.size() != 4) begin n_err++; $display("FAIL b2b_nvalid: got %0d want 4", qop.size()); end
        n_chk++; if (qcode.size() != 0) begin n_err++; $display("FAIL b2b_nerr: got %0d want 0", qcode.size()); end
        for (int k = 0; k < qop.size() && k < 4; k++) begin
            n_chk++; if (qop[k] !== 2'(k)) begin n_err++; $display("FAIL b2b_op%0d: got %0d want %0d", k, qop[k], k); end
        end
    endtask

    task automatic test_bad_opcode();
        clear_q();
        send_cmd(8'h5a, 8'ha5, 8'h0c);
        send_cmd(8'h11, 8'h22, 8'h10);
        n_chk++; if (qa.size() != 1) begin n_err++; $display("FAIL badop_nvalid: got %0d want 1", qa.size()); end
        n_chk++; if (qcode.size() != 1) begin n_err++; $display("FAIL badop_nerr: got %0d want 1", qcode.size()); end
        if (qcode.size() == 1) begin
            n_chk++; if (qcode[0] !== 2'd3) begin n_err++; $display("FAIL badop_code: got %0d want 3", qcode[0]); end
        end
        n_chk++; if (cmd_a !== 8'h5a) begin n_err++; $display("FAIL badop_keep_a: got %h want 5a", cmd_a); end
        n_chk++; if (cmd_b !== 8'ha5) begin n_err++; $display("FAIL badop_keep_b: got %h want a5", cmd_b); end
        n_chk++; if (cmd_op !== 2'd2) begin n_err++; $display("FAIL badop_keep_op: got %0d want 2", cmd_op); end
    endtask

    task automatic test_byte_error(input logic pflip, input logic stopb, input logic [1:0] want);
        int tbad;
        clear_q();
        send_byte(8'h0f, 1'b0, 1'b1);
        send_byte(8'h0e, pflip, stopb);
        tbad = t_start;
        idle_bits(2);
        send_cmd(8'h0f, 8'h0e, 8'h0a);
        n_chk++; if (qcode.size() != 1) begin n_err++; $display("FAIL byteerr%0d_nerr: got %0d want 1", want, qcode.size()); end
        if (qcode.size() == 1) begin
            n_chk++; if (qcode[0] !== want) begin n_err++; $display("FAIL byteerr%0d_code: got %0d want %0d", want, qcode[0], want); end
            n_chk++; if (qecyc[0] != tbad + LAT) begin n_err++; $display("FAIL byteerr%0d_latency: got %0d want %0d", want, qecyc[0], tbad + LAT); end
        end
        n_chk++; if (qa.size() != 1) begin n_err++; $display("FAIL byteerr%0d_nvalid: got %0d want 1", want, qa.size()); end
        if (qa.size() == 1) begin
            n_chk++; if (qa[0] !== 8'h0f || qb[0] !== 8'h0e) begin n_err++; $display("FAIL byteerr%0d_ab: got %h/%h want 0f/0e", want, qa[0], qb[0]); end
        end
    endtask

    task automatic test_glitch();
        clear_q();
        RX = 1'b0;
        repeat (C / 4) @(negedge clk);
        idle_bits(12);
        n_chk++; if (qa.size() + qcode.size() != 0) begin n_err++; $display("FAIL glitch_quiet: got %0d pulses want 0", qa.size() + qcode.size()); end
        send_cmd(8'h21, 8'h43, 8'h0d);
        n_chk++; if (qa.size() != 1) begin n_err++; $display("FAIL glitch_nvalid: got %0d want 1", qa.size()); end
        if (qa.size() == 1) begin
            n_chk++; if (qa[0] !== 8'h21 || qb[0] !== 8'h43 || qop[0] !== 2'd3) begin n_err++; $display("FAIL glitch_cmd: got %h/%h/%0d want 21/43/3", qa[0], qb[0], qop[0]); end
        end
    endtask

    task automatic test_abort(input bit use_reset, input logic [7:0] a, input logic [7:0] b, input logic [7:0] o, input logic [1:0] wop);
        clear_q();
        send_byte(8'h55, 1'b0, 1'b1);
        send_partial(8'h33, 3);
        RX = 1'b1;
        if (use_reset) begin
            res = 1'b1;
            @(negedge clk);
            res = 1'b0;
            n_chk++; if (cmd_a !== 8'h00) begin n_err++; $display("FAIL abort_reset_a: got %h want 00", cmd_a); end
        end else begin
            en_RX_in = 1'b0;
            repeat (4) @(negedge clk);
            en_RX_in = 1'b1;
        end
        idle_bits(12);
        send_cmd(a, b, o);
        n_chk++; if (qcode.size() != 0) begin n_err++; $display("FAIL abort%0d_nerr: got %0d want 0", use_reset, qcode.size()); end
        n_chk++; if (qa.size() != 1) begin n_err++; $display("FAIL abort%0d_nvalid: got %0d want 1", use_reset, qa.size()); end
        if (qa.size() == 1) begin
            n_chk++; if (qa[0] !== a || qb[0] !== b || qop[0] !== wop) begin n_err++; $display("FAIL abort%0d_cmd: got %h/%h/%0d want %h/%h/%0d", use_reset, qa[0], qb[0], qop[0], a, b, wop); end
        end
    endtask

`ifdef CMD_TIMEOUT_EN
    task automatic test_timeout();
        int t0;
        clear_q();
        send_byte(8'h0f, 1'b0, 1'b1);
        t0 = t_start;
        idle_bits(2 * TOB);
        n_chk++; if (qcode.size() != 1) begin n_err++; $display("FAIL timeout_nerr: got %0d want 1", qcode.size()); end
        if (qcode.size() == 1) begin
            n_chk++; if (qcode[0] !== 2'd0) begin n_err++; $display("FAIL timeout_code: got %0d want 0", qcode[0]); end
            n_chk++; if (qecyc[0] != t0 + LAT + TOB * C) begin n_err++; $display("FAIL timeout_latency: got %0d want %0d", qecyc[0], t0 + LAT + TOB * C); end
        end
        n_chk++; if (qa.size() != 0) begin n_err++; $display("FAIL timeout_nvalid: got %0d want 0", qa.size()); end
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_back_to_back();
        test_bad_opcode();
        test_byte_error(1'b1, 1'b1, 2'd1);
        test_byte_error(1'b0, 1'b0, 2'd2);
        test_glitch();
        test_abort(1'b1, 8'h0f, 8'h0e, 8'h0b, 2'd1);
        test_abort(1'b0, 8'h3c, 8'hc3, 8'h0a, 2'd0);
`ifdef CMD_TIMEOUT_EN
        test_timeout();
`endif
        n_chk++; if (saw_both) begin n_err++; $display("FAIL valid_err_overlap: got 1 want 0"); end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_cmd_rx.md
Name: uart_cmd_rx

Overview:
- UART command receiver: deserialises 11-bit frames from RX at 115200 baud (100 MHz clk) and checks even parity and the stop bit.
- Assembles three consecutive bytes into one command: operand A, operand B, opcode.
- Presents the command to the downstream ALU/command logic as a single-cycle valid pulse, and reports errors on a separate pulse.
- Frame format on the line, in time order: start(0), D0..D7 (LSB first), even parity bit (XOR of D7..D0), stop(1).

Parameters:
- C_BPS, 868, clock cycles per bit (100 MHz / 115200).
- CNT_W, 11, width of the bit-period counter; must satisfy 2^CNT_W > C_BPS.
- TIMEOUT_BITS, 32, inter-byte gap limit in bit-times. Used only with CMD_TIMEOUT_EN.

Ports:
- clk  input  1  system clock, 100 MHz, rising edge.
- res  input  1  reset, synchronous, active-high.
- RX  input  1  asynchronous serial input; idles high.
- en_RX_in  input  1  receive enable; when low the receiver is held idle.
- cmd_valid  output  1  one-cycle pulse: cmd_a/cmd_b/cmd_op are valid.
- cmd_a  output  8  operand A (first byte of the command).
- cmd_b  output  8  operand B (second byte of the command).
- cmd_op  output  2  decoded opcode: 0=ADD, 1=SUB, 2=AND, 3=OR.
- cmd_err  output  1  one-cycle error pulse.
- cmd_err_code  output  2  error cause, valid with cmd_err: 0=timeout, 1=parity, 2=framing, 3=bad opcode.

Behaviour:
- Reset (res=1 at a clk edge): byte FSM goes to IDLE; byte index = 0; all counters = 0.
  - Outputs after reset: cmd_valid=0, cmd_err=0, cmd_a=0, cmd_b=0, cmd_op=0, cmd_err_code=0.
  - A frame in progress is discarded.
- RX passes through a 2-flop synchroniser whose reset value is 1. All decisions use the synchronised value rxs.
- Byte FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: on rxs=0 while en_RX_in=1, clear cnt and go to START.
  - START: when cnt==C_BPS/2-1 (433), sample rxs.
    - rxs=1: treat as a glitch; return to IDLE with no output.
    - rxs=0: clear cnt, go to DATA.
  - DATA: sample when cnt==C_BPS-1 and shift into the data register LSB-first. After 8 samples go to PARITY.
  - PARITY: sample the parity bit at cnt==C_BPS-1; go to STOP.
  - STOP: sample at cnt==C_BPS-1, then go directly to IDLE in the same cycle. The receiver is therefore ready for a back-to-back start bit.
  - Every sample lands at mid-bit.
- Byte checks, evaluated in the STOP sample cycle, in priority order:
  - stop bit = 0: framing error, code 2.
  - parity != XOR of data: parity error, code 1.
- Command assembly on each good byte:
  - idx 0: store to cmd_a, idx becomes 1.
  - idx 1: store to cmd_b, idx becomes 2.
  - idx 2: decode 0x0a→0, 0x0b→1, 0x0c→2, 0x0d→3, and raise cmd_valid. Any other value raises cmd_err with code 3.
  - idx returns to 0 after byte 2 in both cases.
- Any error: cmd_err pulses, idx resets to 0, the offending byte is discarded.
  - cmd_a/cmd_b keep their last values.
  - cmd_valid and cmd_err are never high in the same cycle.
- Latency: cmd_valid / cmd_err assert exactly one clk after the stop-bit sample cycle, for exactly one cycle. cmd_a/cmd_b/cmd_op are stable from that cycle until the next cmd_valid.
- en_RX_in low: FSM is forced to IDLE and idx to 0 at the next edge; a partial frame is aborted with no error. Reset has priority over en_RX_in.
- cnt saturates only by state transitions and never wraps inside a bit period.

Optional Feature:
- Macro: CMD_TIMEOUT_EN.
- Defined: a gap counter runs while idx!=0 and the FSM is in IDLE; it clears on every start-bit detection.
  - When the gap reaches TIMEOUT_BITS*C_BPS cycles: cmd_err pulses with code 0 and idx resets to 0.
- Undefined: no gap counter exists; a partial command waits indefinitely. Code 0 is never produced.

Test Plan:
- Frames 0x0f (p=0), 0x0e (p=1), 0x0a (p=0) at 868 cycles/bit, with 1 idle bit between commands → one cmd_valid with cmd_a=0x0f, cmd_b=0x0e, cmd_op=0, one clk after the third stop-bit sample.
- Four consecutive commands with opcode bytes 0x0a, 0x0b (p=1), 0x0c (p=0), 0x0d (p=1), operands 0x0f/0x0e → cmd_op sequence 0,1,2,3, four cmd_valid pulses, no cmd_err.
- Second byte 0x0e sent with parity 0, then a correct full command → cmd_err with code 1 and no cmd_valid; the following command yields cmd_valid with a=0x0f, b=0x0e.
  - Repeat with stop bit 0 → cmd_err with code 2.
- Opcode byte 0x10 → cmd_err with code 3. RX low pulse of 100 cycles → no output, FSM back in IDLE.
- res=1 for one cycle midway through byte 1, or en_RX_in dropped mid-frame → no output; the next full command decodes correctly.
  - With CMD_TIMEOUT_EN: send only 0x0f, then idle 40 bit-times → cmd_err code 0 at 32*868 cycles after the stop sample.
